// File: rtl/ifmap_mem_stream.sv
// Input-feature-map memory: bit-serial load of NUM_TS binary spike maps, then a row burst to
// every PE on start/timestep-done, then per-PE next-row replies as {dest, opcode, data}.
module ifmap_mem_stream #(
  parameter int unsigned IFMAP_SIZE   = 25,
  parameter int unsigned NUM_TS       = 2,
  parameter int unsigned NUM_PE       = 5,
  parameter int unsigned PE_BASE_ID   = 5,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned OP_W         = 4,
  parameter int unsigned OP_START     = 0,
  parameter int unsigned OP_TS_DONE   = 15,
  parameter int unsigned OP_PPE_INPUT = 1,
  parameter int unsigned OP_EOR       = 14,
  parameter int unsigned PKT_W        = ADDR_W + OP_W + IFMAP_SIZE,
  localparam int unsigned TS_W        = (NUM_TS > 1) ? $clog2(NUM_TS) : 1,
  localparam int unsigned IDX_W       = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [TS_W-1:0]  load_ts,
  input  logic [IDX_W-1:0] load_row,
  input  logic [IDX_W-1:0] load_col,
  input  logic             load_data,
  output logic             load_done,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PKT_W-1:0] req_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic [TS_W-1:0]  cur_ts,
  output logic             err_bad_op
);

  localparam int unsigned NUM_ROWS = NUM_TS * IFMAP_SIZE;
  localparam int unsigned TOTAL    = NUM_ROWS * IFMAP_SIZE;
  localparam int unsigned CNT_W    = $clog2(TOTAL + 1);
  localparam int unsigned PTR_W    = $clog2(IFMAP_SIZE + 1);
  localparam int unsigned MEM_AW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned PE_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [1:0] {StIdle, StServe, StBurst, StReply} state_e;

  state_e                state_q;
  logic [IFMAP_SIZE-1:0] mem [NUM_ROWS];
  logic [TS_W-1:0]       cur_ts_q;
  logic [PTR_W-1:0]      ptr_q [NUM_PE];
  logic [PE_W-1:0]       bst_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  load_done_q;
  logic                  out_valid_q;
  logic [PKT_W-1:0]      out_pkt_q;
  logic                  err_q;

  function automatic logic [MEM_AW-1:0] row_addr(input logic [TS_W-1:0]  ts,
                                                 input logic [PTR_W-1:0] row);
    return MEM_AW'(ts) * MEM_AW'(IFMAP_SIZE) + MEM_AW'(row);
  endfunction

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [ADDR_W-1:0]     dest,
                                              input logic [OP_W-1:0]       op,
                                              input logic [IFMAP_SIZE-1:0] data);
    return {dest, op, data};
  endfunction

  // Extra MSB on the range checks keeps them meaningful for any parameter set.
  logic              load_ok;
  logic [MEM_AW-1:0] wr_addr;
  assign load_ok = load_valid
                && ({1'b0, load_ts}  < (TS_W + 1)'(NUM_TS))
                && ({1'b0, load_row} < (IDX_W + 1)'(IFMAP_SIZE))
                && ({1'b0, load_col} < (IDX_W + 1)'(IFMAP_SIZE));
  assign wr_addr = row_addr(load_ts, PTR_W'(load_row));

  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[wr_addr][load_col] <= load_data;
    end
  end

  logic [ADDR_W-1:0] req_src;
  logic [OP_W-1:0]   req_op;
  logic              req_fire;
  logic              req_is_burst;
  logic              req_is_pe;
  logic [PE_W-1:0]   req_pe;
  logic [TS_W-1:0]   ts_nxt;
  logic [TS_W-1:0]   burst_ts;
  logic [PE_W-1:0]   bst_nxt;
  logic              unused_req_data;

  assign req_src      = req_pkt[PKT_W-1 -: ADDR_W];
  assign req_op       = req_pkt[PKT_W-ADDR_W-1 -: OP_W];
  assign req_fire     = req_valid && req_ready;
  assign req_is_burst = (req_op == OP_W'(OP_START)) || (req_op == OP_W'(OP_TS_DONE));
  assign req_is_pe    = (int'(req_op) == int'(req_src)) && (int'(req_src) >= PE_BASE_ID)
                     && (int'(req_src) < PE_BASE_ID + NUM_PE);
  assign req_pe       = PE_W'(req_src - ADDR_W'(PE_BASE_ID));
  assign ts_nxt       = (cur_ts_q == TS_W'(NUM_TS - 1)) ? '0 : cur_ts_q + TS_W'(1);
  assign burst_ts     = (req_op == OP_W'(OP_TS_DONE)) ? ts_nxt : cur_ts_q;
  assign bst_nxt      = bst_q + PE_W'(1);
  assign unused_req_data = ^req_pkt[IFMAP_SIZE-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_ts_q    <= '0;
      bst_q       <= '0;
      cnt_q       <= '0;
      load_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      err_q       <= 1'b0;
      for (int k = 0; k < NUM_PE; k++) begin
        ptr_q[k] <= '0;
      end
    end else begin
      if (load_ok && (cnt_q != CNT_W'(TOTAL))) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      load_done_q <= (cnt_q == CNT_W'(TOTAL));

      unique case (state_q)
        StIdle: begin
          if (load_done_q) state_q <= StServe;
        end
        StServe: begin
          if (req_fire) begin
            if (req_is_burst) begin
              cur_ts_q    <= burst_ts;
              bst_q       <= '0;
              out_valid_q <= 1'b1;
              out_pkt_q   <= mk_pkt(ADDR_W'(PE_BASE_ID), OP_W'(OP_PPE_INPUT),
                                    mem[row_addr(burst_ts, '0)]);
              state_q     <= StBurst;
            end else if (req_is_pe) begin
              out_valid_q <= 1'b1;
              state_q     <= StReply;
              if (ptr_q[req_pe] < PTR_W'(IFMAP_SIZE)) begin
                out_pkt_q     <= mk_pkt(req_src, OP_W'(OP_PPE_INPUT),
                                        mem[row_addr(cur_ts_q, ptr_q[req_pe])]);
                ptr_q[req_pe] <= ptr_q[req_pe] + PTR_W'(1);
              end else begin
                out_pkt_q <= mk_pkt(req_src, OP_W'(OP_EOR), '0);
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StBurst: begin
          if (out_ready) begin
            if (bst_q == PE_W'(NUM_PE - 1)) begin
              out_valid_q <= 1'b0;
              state_q     <= StServe;
              // Each PE already holds its first row, so its next request is row k+1.
              for (int k = 0; k < NUM_PE; k++) begin
                ptr_q[k] <= PTR_W'(k + 1);
              end
            end else begin
              bst_q     <= bst_nxt;
              out_pkt_q <= mk_pkt(ADDR_W'(PE_BASE_ID) + ADDR_W'(bst_nxt), OP_W'(OP_PPE_INPUT),
                                  mem[row_addr(cur_ts_q, PTR_W'(bst_nxt))]);
            end
          end
        end
        StReply: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StServe;
          end
        end
      endcase
    end
  end

  assign load_ready = 1'b1;
  assign load_done  = load_done_q;
  assign req_ready  = (state_q == StServe) && load_done_q;
  assign out_valid  = out_valid_q;
  assign out_pkt    = out_pkt_q;
  assign cur_ts     = cur_ts_q;
  assign err_bad_op = err_q;

endmodule

// File: doc/ifmap_mem_stream.md
Name: ifmap_mem_stream

Overview:
- Clocked, parametrised input-feature-map memory for the SNN convolution array.
- Stores NUM_TS timesteps of an IFMAP_SIZE x IFMAP_SIZE binary spike map, written one bit at a time.
- On a start or timestep-done packet it bursts one row to each of NUM_PE partial-sum PEs.
- It then serves per-PE next-row requests using independent row pointers, in packet format {dest, opcode, data}.

Parameters:
- IFMAP_SIZE, 25: row length and row count of the map.
- NUM_TS, 2: timesteps stored.
- NUM_PE, 5: PEs served; PE k has node ID PE_BASE_ID+k.
- PE_BASE_ID, 5: node ID of PE 0.
- ADDR_W, 4: dest-address field width.
- OP_W, 4: opcode field width.
- OP_START, 0: start opcode (weights loaded).
- OP_TS_DONE, 15: timestep-done opcode.
- OP_PPE_INPUT, 1: opcode on outgoing row packets.
- OP_EOR, 14: opcode on end-of-rows replies.
- PKT_W, ADDR_W+OP_W+IFMAP_SIZE: packet width, derived.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- load_valid  in  1  bit-write request
- load_ready  out  1  write accepted when high with load_valid
- load_ts  in  clog2(NUM_TS)  target timestep
- load_row  in  clog2(IFMAP_SIZE)  row index
- load_col  in  clog2(IFMAP_SIZE)  column index; maps to data bit col (LSB = col 0)
- load_data  in  1  spike bit
- load_done  out  1  level; all NUM_TS*IFMAP_SIZE^2 writes accepted
- req_valid  in  1  incoming packet valid
- req_ready  out  1  packet accepted
- req_pkt  in  PKT_W  [PKT_W-1 -: ADDR_W] source ID, next OP_W bits opcode, rest data (ignored)
- out_valid  out  1  outgoing packet valid
- out_ready  in  1  router accepts
- out_pkt  out  PKT_W  {dest, opcode, row data}
- cur_ts  out  clog2(NUM_TS)  timestep being served
- err_bad_op  out  1  sticky; unknown opcode or out-of-range source seen

Behaviour:
- Reset (async, immediate):
  - state=IDLE; cur_ts=0; all pointers=0; write counter=0.
  - load_done=0, out_valid=0, out_pkt=0, err_bad_op=0.
  - load_ready=1, req_ready=0.
  - Memory contents are not cleared.
- Storage is NUM_TS*IFMAP_SIZE rows of IFMAP_SIZE bits.
- Load path:
  - load_ready is always 1.
  - Each accepted write sets the bit and increments the write counter, saturating at NUM_TS*IFMAP_SIZE^2.
  - load_done rises the cycle after the counter reaches the total.
  - Out-of-range row/col writes are discarded and not counted.
- req_ready is 1 only in state SERVE with load_done=1.
- FSM states:
  - IDLE: go to SERVE when load_done=1.
  - SERVE, accepted OP_START: burst index=0, go to BURST.
  - SERVE, accepted OP_TS_DONE: cur_ts=(cur_ts+1) mod NUM_TS (NUM_TS-1 wraps to 0), burst index=0, go to BURST.
  - SERVE, accepted opcode equal to source ID (PE_BASE_ID+k, k<NUM_PE): row request from PE k, go to REPLY.
    - ptr[k]<IFMAP_SIZE: register {source ID, OP_PPE_INPUT, row ptr[k] of cur_ts}; ptr[k]++.
    - ptr[k]>=IFMAP_SIZE: register {source ID, OP_EOR, 0}; ptr[k] unchanged.
  - SERVE, any other opcode: dropped, err_bad_op=1, stay in SERVE.
  - BURST: out_pkt={PE_BASE_ID+i, OP_PPE_INPUT, row i of cur_ts}. On each out handshake i++. After the handshake for i=NUM_PE-1: ptr[k]=k+1 for all k, go to SERVE.
  - REPLY: hold the packet until the out handshake, then go to SERVE.
- Latency: request accepted at cycle N gives out_valid=1 at N+1. Burst packets are back-to-back when out_ready=1.
- out_pkt is stable while out_valid=1 and out_ready=0.
- A load write in the same cycle as request acceptance, to the same row: the reply carries pre-write data.
- Reset mid-BURST/REPLY: out_valid drops immediately and the pending packet is discarded.

Test Plan:
- Load 1250 bits (ts0 all ones, ts1 checkerboard), then OP_START -> load_done=1; 5 packets, dests 5..9, opcode 1, data 0x1FFFFFF, back-to-back.
- PE 7 requests 3 times, with out_ready stalled 4 cycles on the first -> rows 3,4,5 of ts0; out_pkt stable during stall; each reply 1 cycle after acceptance.
- PE 9 requests until exhausted -> rows 5..24 (20 replies), then opcode 14 with data 0, and pointer unchanged on a repeat request.
- OP_TS_DONE -> cur_ts=1; burst of checkerboard rows 0..4 (0x1555555 / 0x0AAAAAA alternating); a second OP_TS_DONE wraps cur_ts to 0.
- Opcode 3, and source ID 12 -> no out_valid; err_bad_op=1 and sticky.
- rst asserted mid-burst after 2 packets -> out_valid=0 immediately, cur_ts=0, load_done=0; requests refused until reload.
